// File: rtl/seq_edge_tagger_if.sv
// Record stream between the edge tagger and the acquisition path.
// The producer drives rec_data/rec_valid; the consumer answers with rec_ready.
interface seq_edge_tagger_if #(
  parameter int TS_WIDTH = 36
) ();

  logic [TS_WIDTH+8:0] rec_data;
  logic                rec_valid;
  logic                rec_ready;

  modport master (
    output rec_data,
    output rec_valid,
    input  rec_ready
  );

  modport slave (
    input  rec_data,
    input  rec_valid,
    output rec_ready
  );

endinterface

// File: rtl/seq_edge_tagger.sv
// Sequencer edge tagger: samples the four sequencer channels, detects
// per-channel transitions, stamps them with a free-running timestamp and
// queues the records in a first-word-fall-through FIFO. A record is also
// queued whenever the sampled timestamp is zero so the consumer can track
// timestamp wraps. Records dropped on a full FIFO are counted, and the next
// stored record carries a lost flag.
module seq_edge_tagger #(
  parameter int TS_WIDTH   = 36,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              seq_in,
  input  logic                    enable,
  input  logic [3:0]              mask,
  input  logic                    clear_lost,
  seq_edge_tagger_if.master       rec,
  output logic [15:0]             lost_count
);

  localparam int REC_W = TS_WIDTH + 9;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  // Saturating increment for the dropped-record counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Free-running timestamp and stage-1 sample registers.
  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] ts_p1;
  logic [3:0]          seq_p1;
  logic [3:0]          prev_p1;
  // smp_vld: seq_p1 holds a real sample; primed: prev_p1 holds one too.
  logic                smp_vld;
  logic                primed;

  // Event detection.
  logic [3:0]          edges;
  logic                wrap;
  logic                write;
  logic [REC_W-1:0]    rec_word;

  // FIFO storage and control.
  logic [REC_W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [CW-1:0]       mem_cnt;   // entries in mem not yet on the output
  logic [CW-1:0]       occ;       // mem_cnt plus the output register
  logic                full;
  logic                wr_en;
  logic                drop;
  logic                pop;
  logic                load;
  logic [REC_W-1:0]    out_data;
  logic                out_valid;
  logic                lost_pending;

  // ---- stage p0 -> p1: sample inputs and timestamp ----
  // Timestamp counter and input sampling; the detector arms only once two
  // real samples exist, so release from reset never produces a record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts      <= '0;
      ts_p1   <= '0;
      seq_p1  <= 4'h0;
      prev_p1 <= 4'h0;
      smp_vld <= 1'b0;
      primed  <= 1'b0;
    end else begin
      ts      <= ts + TS_WIDTH'(1);
      ts_p1   <= ts;
      seq_p1  <= seq_in;
      prev_p1 <= seq_p1;
      smp_vld <= 1'b1;
      primed  <= smp_vld;
    end
  end

  // ---- stage p1 -> p2: detect event, write FIFO ----
  // prev_p1 tracks seq_p1 regardless of enable, so enabling is glitch-free.
  assign edges    = (seq_p1 ^ prev_p1) & mask;
  assign wrap     = (ts_p1 == '0);
  assign write    = enable & primed & ((edges != 4'h0) | wrap);
  assign rec_word = {lost_pending, edges, seq_p1, ts_p1};

  // Fullness uses registered occupancy: a same-cycle read does not free a slot.
  assign full     = (occ == CW'(FIFO_DEPTH));
  assign wr_en    = write & ~full;
  assign drop     = write & full;
  assign pop      = out_valid & rec.rec_ready;
  assign load     = (mem_cnt != '0) & (~out_valid | pop);

  // Record storage array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= rec_word;
    end
  end

  // Pointers and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      occ     <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + AW'(1);
      end
      if (load) begin
        rptr <= rptr + AW'(1);
      end
      case ({wr_en, load})
        2'b10:   mem_cnt <= mem_cnt + CW'(1);
        2'b01:   mem_cnt <= mem_cnt - CW'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      case ({wr_en, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // ---- stage p2: output register ----
  // Fall-through output register; holds its record until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= mem[rptr];
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  // Lost tracking; a drop in the same cycle as clear_lost wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lost_pending <= 1'b0;
      lost_count   <= 16'h0000;
    end else if (drop) begin
      lost_pending <= 1'b1;
      lost_count   <= clear_lost ? 16'h0001 : sat_inc16(lost_count);
    end else if (clear_lost) begin
      lost_pending <= 1'b0;
      lost_count   <= 16'h0000;
    end else if (wr_en) begin
      lost_pending <= 1'b0;
    end
  end

  assign rec.rec_data  = out_data;
  assign rec.rec_valid = out_valid;

endmodule

// File: tb/tb_seq_edge_tagger.sv
// Directed bench for seq_edge_tagger with an 8-bit timestamp so that wraps
// occur every 256 cycles. Inputs are driven and outputs sampled 1 time unit
// after the rising edge. Record layout: {lost, edges[3:0], level[3:0], ts[7:0]}.
module tb_seq_edge_tagger;

  logic        clk;
  logic        reset;
  logic [3:0]  seq_in;
  logic        enable;
  logic [3:0]  mask;
  logic        clear_lost;
  logic [15:0] lost_count;
  int          checks;
  int          failures;

  seq_edge_tagger_if #(.TS_WIDTH(8)) rec_if ();

  seq_edge_tagger #(.TS_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .seq_in     (seq_in),
    .enable     (enable),
    .mask       (mask),
    .clear_lost (clear_lost),
    .rec        (rec_if.master),
    .lost_count (lost_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, then release just after an edge: the next edge is edge 1 and
  // after k steps the timestamp counter reads k.
  task automatic do_reset(input logic [3:0] s, input logic en, input logic [3:0] m,
                          input logic rdy);
    seq_in            = s;
    enable            = en;
    mask              = m;
    rec_if.rec_ready  = rdy;
    clear_lost        = 1'b0;
    reset             = 1'b1;
    step(2);
    reset             = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(4'h0, 1'b1, 4'hF, 1'b1);
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", rec_if.rec_valid);
    end
    checks++;
    if (rec_if.rec_data !== 17'h00000) begin
      failures++;
      $display("FAIL reset_data got=%h want=00000", rec_if.rec_data);
    end
    checks++;
    if (lost_count !== 16'h0000) begin
      failures++;
      $display("FAIL reset_lost got=%h want=0000", lost_count);
    end
  endtask

  task automatic test_single_edge();
    do_reset(4'h0, 1'b1, 4'hF, 1'b1);
    step(20);
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got=%b want=0", rec_if.rec_valid);
    end
    seq_in = 4'h1;
    step(1);                       // sampled with ts=20
    step(1);
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early got=%b want=0", rec_if.rec_valid);
    end
    step(1);
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 17'h01114) begin
      failures++;
      $display("FAIL single_rec got=%b/%h want=1/01114", rec_if.rec_valid, rec_if.rec_data);
    end
    step(1);
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_after got=%b want=0", rec_if.rec_valid);
    end
  endtask

  task automatic test_mask();
    do_reset(4'h0, 1'b1, 4'h5, 1'b1);
    step(5);
    seq_in = 4'hF;
    step(3);                       // sampled with ts=5
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 17'h05F05) begin
      failures++;
      $display("FAIL mask_rec got=%b/%h want=1/05F05", rec_if.rec_valid, rec_if.rec_data);
    end
    step(1);
    seq_in = 4'hD;                 // only channel 1 changes; it is masked
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++;
      if (rec_if.rec_valid !== 1'b0) begin
        failures++;
        $display("FAIL mask_suppressed cyc=%0d got=%b want=0", i, rec_if.rec_valid);
      end
    end
  endtask

  task automatic test_overflow();
    logic [16:0] exp;
    logic [3:0]  lvl;
    logic [7:0]  tsv;
    do_reset(4'h0, 1'b1, 4'hF, 1'b0);
    step(3);
    for (int i = 0; i < 20; i++) begin
      seq_in = seq_in ^ 4'h1;      // sampled with ts=3+i
      step(1);
      if (i >= 2) begin
        checks++;
        if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 17'h01103) begin
          failures++;
          $display("FAIL ovf_hold i=%0d got=%b/%h want=1/01103", i, rec_if.rec_valid,
                   rec_if.rec_data);
        end
      end
    end
    step(2);
    checks++;
    if (lost_count !== 16'd4) begin
      failures++;
      $display("FAIL ovf_lost got=%0d want=4", lost_count);
    end
    rec_if.rec_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      lvl = (k % 2 == 0) ? 4'h1 : 4'h0;
      tsv = 8'(3 + k);
      exp = {1'b0, 4'h1, lvl, tsv};
      checks++;
      if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== exp) begin
        failures++;
        $display("FAIL ovf_drain k=%0d got=%b/%h want=1/%h", k, rec_if.rec_valid,
                 rec_if.rec_data, exp);
      end
      step(1);
    end
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_empty got=%b want=0", rec_if.rec_valid);
    end
    seq_in = 4'h1;
    step(3);                       // sampled with ts=41
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 17'h11129) begin
      failures++;
      $display("FAIL ovf_lost_flag got=%b/%h want=1/11129", rec_if.rec_valid, rec_if.rec_data);
    end
    seq_in = 4'h0;
    step(3);                       // sampled with ts=44
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 17'h0102C) begin
      failures++;
      $display("FAIL ovf_flag_cleared got=%b/%h want=1/0102C", rec_if.rec_valid,
               rec_if.rec_data);
    end
  endtask

  task automatic test_wrap();
    do_reset(4'hA, 1'b1, 4'hF, 1'b0);
    step(258);
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_none got=%b want=0", rec_if.rec_valid);
    end
    step(1);
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 17'h00A00) begin
      failures++;
      $display("FAIL wrap_first got=%b/%h want=1/00A00", rec_if.rec_valid, rec_if.rec_data);
    end
    rec_if.rec_ready = 1'b1;
    step(1);
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pop got=%b want=0", rec_if.rec_valid);
    end
    step(254);
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_gap got=%b want=0", rec_if.rec_valid);
    end
    step(1);
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 17'h00A00) begin
      failures++;
      $display("FAIL wrap_second got=%b/%h want=1/00A00", rec_if.rec_valid, rec_if.rec_data);
    end
    step(253);
    seq_in = 4'h9;                 // sampled with ts=0
    step(2);
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_comb_early got=%b want=0", rec_if.rec_valid);
    end
    step(1);
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 17'h03900) begin
      failures++;
      $display("FAIL wrap_combined got=%b/%h want=1/03900", rec_if.rec_valid, rec_if.rec_data);
    end
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++;
      if (rec_if.rec_valid !== 1'b0) begin
        failures++;
        $display("FAIL wrap_single cyc=%0d got=%b want=0", i, rec_if.rec_valid);
      end
    end
  endtask

  task automatic test_clear_lost();
    do_reset(4'h0, 1'b1, 4'hF, 1'b0);
    step(3);
    for (int i = 0; i < 19; i++) begin
      seq_in = seq_in ^ 4'h1;
      step(1);
    end
    step(1);
    checks++;
    if (lost_count !== 16'd3) begin
      failures++;
      $display("FAIL clr_pre got=%0d want=3", lost_count);
    end
    seq_in = seq_in ^ 4'h1;
    step(1);
    clear_lost = 1'b1;             // same cycle as the dropped write
    step(1);
    clear_lost = 1'b0;
    checks++;
    if (lost_count !== 16'd1) begin
      failures++;
      $display("FAIL clr_collision got=%0d want=1", lost_count);
    end
    clear_lost = 1'b1;
    step(1);
    clear_lost = 1'b0;
    checks++;
    if (lost_count !== 16'd0) begin
      failures++;
      $display("FAIL clr_alone got=%0d want=0", lost_count);
    end
  endtask

  task automatic test_reset_midstream();
    logic [3:0] vals [5];
    vals[0] = 4'h1; vals[1] = 4'h0; vals[2] = 4'h1; vals[3] = 4'h0; vals[4] = 4'hF;
    do_reset(4'h0, 1'b1, 4'hF, 1'b0);
    step(3);
    for (int i = 0; i < 5; i++) begin
      seq_in = vals[i];
      step(1);
    end
    step(3);
    checks++;
    if (rec_if.rec_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_queued got=%b want=1", rec_if.rec_valid);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (rec_if.rec_valid !== 1'b0 || lost_count !== 16'h0000) begin
      failures++;
      $display("FAIL mid_async got=%b/%h want=0/0000", rec_if.rec_valid, lost_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (rec_if.rec_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_after_release cyc=%0d got=%b want=0", i, rec_if.rec_valid);
      end
    end
    enable = 1'b0;
    seq_in = 4'h3;                 // edges while disabled are ignored
    step(5);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (rec_if.rec_valid !== 1'b0) begin
        failures++;
        $display("FAIL en_rise cyc=%0d got=%b want=0", i, rec_if.rec_valid);
      end
    end
    seq_in = 4'h2;                 // sampled with ts=35
    step(3);
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 17'h01223) begin
      failures++;
      $display("FAIL en_edge got=%b/%h want=1/01223", rec_if.rec_valid, rec_if.rec_data);
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    seq_in           = 4'h0;
    enable           = 1'b0;
    mask             = 4'hF;
    clear_lost       = 1'b0;
    rec_if.rec_ready = 1'b0;
    test_reset();
    test_single_edge();
    test_mask();
    test_overflow();
    test_wrap();
    test_clear_lost();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
